// File: rtl/i2s_pkg.sv
// i2s_pkg: slot geometry and channel encoding shared by the I2S transmitter
// and the i2s_if receiver, so both sides agree on the wire format.
package i2s_pkg;

  localparam int SLOT_W   = 32;
  localparam int SAMPLE_W = 24;
  localparam int PAD_LSB  = 7;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } ws_chan_e;

  // One leading padding bit (sent on the WS edge), the sample MSB-first,
  // then zero padding to fill the slot.
  function automatic logic [SLOT_W-1:0] slot_word(input logic [SAMPLE_W-1:0] sample);
    return {1'b0, sample, {PAD_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides the system clock down to the I2S bit clock.
//   clk      in   system clock, rising edge
//   rstn     in   synchronous active-low reset
//   sck      out  registered bit clock, aclk / (2*CLK_DIV)
//   fall_evt out  high for the one aclk cycle whose edge drives sck low
module i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic sck,
  output logic fall_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic          r_sck;
  logic          w_wrap;

  assign w_wrap   = (r_div_cnt == DIV_MAX);
  // Combinational so the top can update WS/SD on the same edge SCK falls.
  assign fall_evt = w_wrap & r_sck;
  assign sck      = r_sck;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter for the sonar emitter DAC.
//   s_axis_aclk/aresetn   system clock, synchronous active-low reset
//   s_axis_tdata[23:0]    signed sample (upper byte ignored)
//   s_axis_tuser          channel, 0 = left, 1 = right
//   s_axis_tvalid/tready  AXI-Stream handshake; tready is per channel
//   SCK, WS, SD           registered I2S outputs, 32-bit slots
//   underflow             one-cycle pulse when a slot starts with no sample
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        underflow
);

  logic [SAMPLE_W-1:0] r_buf [2];
  logic [1:0]          r_buf_vld;
  logic [5:0]          r_fcnt;
  logic [SLOT_W-1:0]   r_shreg;
  logic                r_ws;
  logic                r_sd;
  logic                r_uf;

  logic       w_fall;
  logic [5:0] w_n;
  logic       w_ch;
  logic       w_slot_start;
  logic [4:0] w_bit_idx;
  logic       w_hs;
  logic       w_unused_tdata;

  i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (s_axis_aclk),
    .rstn     (s_axis_aresetn),
    .sck      (SCK),
    .fall_evt (w_fall)
  );

  assign w_n            = r_fcnt + 6'd1;
  assign w_ch           = w_n[5];
  assign w_slot_start   = (w_n[4:0] == 5'd0);
  assign w_bit_idx      = 5'd31 - w_n[4:0];
  assign s_axis_tready  = ~r_buf_vld[s_axis_tuser];
  assign w_hs           = s_axis_tvalid & s_axis_tready;
  assign w_unused_tdata = ^s_axis_tdata[31:24];

  assign WS        = r_ws;
  assign SD        = r_sd;
  assign underflow = r_uf;

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_buf_vld <= 2'b00;
      r_fcnt    <= 6'd63;
      r_shreg   <= '0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      r_uf <= 1'b0;
      if (w_fall) begin
        r_fcnt <= w_n;
        r_ws   <= w_ch;
        if (w_slot_start) begin
          r_sd <= 1'b0;
          if (r_buf_vld[w_ch]) begin
            r_shreg         <= slot_word(r_buf[w_ch]);
            r_buf_vld[w_ch] <= 1'b0;
          end else begin
            r_shreg <= '0;
            r_uf    <= 1'b1;
          end
        end else begin
          r_sd <= r_shreg[w_bit_idx];
        end
      end
      // Write after the slot load: tready was low for a buffer being loaded,
      // so the two can only touch different channels in the same cycle.
      if (w_hs) begin
        r_buf[s_axis_tuser]     <= s_axis_tdata[SAMPLE_W-1:0];
        r_buf_vld[s_axis_tuser] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  localparam int CLK_DIV = 2;
  localparam int FRAME   = 64 * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        SCK, WS, SD, underflow;

  i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rstn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .SCK            (SCK),
    .WS             (WS),
    .SD             (SD),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: samples on SCK rising edges, assembles 32-bit slots.
  // The first SCK rise after reset precedes the first slot and is skipped.
  int          d_cnt = 0;
  logic        d_skip = 1'b1;
  logic        d_ws = 1'b0;
  logic [31:0] d_word = '0;
  logic        sck_prev = 1'b0;
  logic        ws_prev = 1'b0;
  int          uf0 = 0;
  int          uf1 = 0;
  int          ws_fall_cyc = -1;

  always @(negedge clk) begin
    if (!rstn) begin
      d_cnt    <= 0;
      d_skip   <= 1'b1;
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
      uf0      <= 0;
      uf1      <= 0;
      rx_q.delete();
    end else begin
      if (SCK === 1'b1 && sck_prev === 1'b0) begin
        if (d_skip) begin
          d_skip <= 1'b0;
        end else begin
          if (d_cnt == 0) d_ws <= WS;
          d_word <= {d_word[30:0], SD};
          if (d_cnt == 31) begin
            rx_q.push_back({d_ws, d_word[30:0], SD});
            d_cnt <= 0;
          end else begin
            d_cnt <= d_cnt + 1;
          end
        end
      end
      if (WS === 1'b0 && ws_prev === 1'b1) ws_fall_cyc <= cyc;
      if (underflow === 1'b1) begin
        if (WS === 1'b1) uf1 <= uf1 + 1;
        else uf0 <= uf0 + 1;
      end
      sck_prev <= SCK;
      ws_prev  <= WS;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic ch, input logic [23:0] s);
    exp_q.push_back({ch, 1'b0, s, 7'b0000000});
  endtask

  // Starts and ends at a negedge. Returns the cycle at which tready was seen
  // high (handshake on the following posedge) and the cycles waited.
  task automatic send(input logic ch, input logic [23:0] d, output int acc, output int w);
    w = 0;
    s_axis_tuser  = ch;
    s_axis_tdata  = {8'hA5, d};
    s_axis_tvalid = 1'b1;
    #1;
    while (s_axis_tready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("send_timeout", 64'(w >= 2000), 64'(0));
    acc = cyc;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic restart();
    rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.delete();
    rstn = 1'b1;
  endtask

  task automatic wait_slots(input int k, input string tag);
    int w;
    w = 0;
    while (rx_q.size() < k && w < k * FRAME / 2 + 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_slot_count"}, 64'(rx_q.size() >= k), 64'(1));
  endtask

  task automatic cmp_slots(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      if (rx_q.size() > 0 && exp_q.size() > 0)
        chk($sformatf("%s_slot%0d", tag, i), 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_ws_high(input string tag);
    int w;
    w = 0;
    while (WS !== 1'b1 && w < FRAME) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ws_rise"}, 64'(WS), 64'(1));
  endtask

  initial begin
    int acc, w, acc3, w3, rc;

    // Reset state
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_axis_tuser = 1'b0;
      #1;
      chk("rst_sck", 64'(SCK), 64'(0));
      chk("rst_ws", 64'(WS), 64'(0));
      chk("rst_sd", 64'(SD), 64'(0));
      chk("rst_uf", 64'(underflow), 64'(0));
      chk("rst_tready_l", 64'(s_axis_tready), 64'(1));
      s_axis_tuser = 1'b1;
      #1;
      chk("rst_tready_r", 64'(s_axis_tready), 64'(1));
    end

    // Basic stereo frame
    restart();
    send(1'b0, 24'h800001, acc, w);
    send(1'b1, 24'h7FFFFE, acc, w);
    push_exp(1'b0, 24'h800001);
    push_exp(1'b1, 24'h7FFFFE);
    wait_slots(2, "basic");
    cmp_slots(2, "basic");

    // Underflow: left samples only
    restart();
    send(1'b0, 24'h123456, acc, w);
    send(1'b0, 24'hABCDEF, acc, w);
    push_exp(1'b0, 24'h123456);
    push_exp(1'b1, 24'h000000);
    push_exp(1'b0, 24'hABCDEF);
    push_exp(1'b1, 24'h000000);
    wait_slots(4, "uf");
    chk("uf_right_pulses", 64'(uf1), 64'(2));
    chk("uf_left_pulses", 64'(uf0), 64'(0));
    cmp_slots(4, "uf");

    // Backpressure: three left beats
    restart();
    send(1'b0, 24'h111111, acc, w);
    chk("bp_beat1_wait", 64'(w), 64'(0));
    send(1'b0, 24'h222222, acc, w);
    send(1'b0, 24'h333333, acc3, w3);
    chk("bp_beat3_stall", 64'(w3 >= FRAME - 8), 64'(1));
    chk("bp_beat3_align", 64'(acc3), 64'(ws_fall_cyc));
    push_exp(1'b0, 24'h111111);
    push_exp(1'b1, 24'h000000);
    push_exp(1'b0, 24'h222222);
    push_exp(1'b1, 24'h000000);
    push_exp(1'b0, 24'h333333);
    wait_slots(5, "bp");
    cmp_slots(5, "bp");

    // Collision: right handshake on the left slot-start load edge
    restart();
    send(1'b0, 24'hC0FFEE, acc, w);
    send(1'b1, 24'h0BEEF0, acc, w);
    send(1'b0, 24'h765432, acc, w);
    push_exp(1'b0, 24'hC0FFEE);
    push_exp(1'b1, 24'h0BEEF0);
    push_exp(1'b0, 24'h765432);
    push_exp(1'b1, 24'hFEDCBA);
    wait_ws_high("coll");
    repeat (FRAME / 2 - 1) @(negedge clk);
    s_axis_tuser  = 1'b1;
    s_axis_tdata  = {8'h5A, 24'hFEDCBA};
    s_axis_tvalid = 1'b1;
    #1;
    chk("coll_tready_r", 64'(s_axis_tready), 64'(1));
    acc = cyc;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("coll_same_cycle", 64'(ws_fall_cyc), 64'(acc + 1));
    wait_slots(4, "coll");
    chk("coll_no_uf", 64'(uf1), 64'(0));
    cmp_slots(4, "coll");

    // Mid-frame reset at fcnt=40, SCK high, SD carrying a 1
    restart();
    send(1'b0, 24'h246802, acc, w);
    send(1'b1, 24'h0F0F0F, acc, w);
    send(1'b0, 24'h13579B, acc, w);
    wait_ws_high("mid");
    rc = cyc;
    send(1'b1, 24'h2468AC, acc, w);
    while (cyc < rc + 34) @(negedge clk);
    #1;
    chk("mid_pre_ws", 64'(WS), 64'(1));
    chk("mid_pre_sd", 64'(SD), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    s_axis_tuser = 1'b0;
    #1;
    chk("mid_sck", 64'(SCK), 64'(0));
    chk("mid_ws", 64'(WS), 64'(0));
    chk("mid_sd", 64'(SD), 64'(0));
    chk("mid_uf", 64'(underflow), 64'(0));
    chk("mid_tready_l", 64'(s_axis_tready), 64'(1));
    s_axis_tuser = 1'b1;
    #1;
    chk("mid_tready_r", 64'(s_axis_tready), 64'(1));
    repeat (3) @(negedge clk);
    exp_q.delete();
    rstn = 1'b1;
    send(1'b0, 24'hA1B2C3, acc, w);
    send(1'b1, 24'h3C2B1A, acc, w);
    push_exp(1'b0, 24'hA1B2C3);
    push_exp(1'b1, 24'h3C2B1A);
    wait_slots(2, "mid");
    chk("mid_no_uf_left", 64'(uf0), 64'(0));
    cmp_slots(2, "mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
